// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

    // Counter width for a WIDTH-bit operation; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/f_adder.sv
// Single-bit full adder.
module f_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    // Combinational sum and carry of three input bits.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one bit pair per clock, LSB first, through a shared
// full adder. Start/busy/done handshake; sum/cout hold the last result.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    bsa_state_t       state, nstate;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum, fa_carry;
    logic             accept, last;

    f_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Requests are only taken when no addition is in flight.
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // Written as shifts so WIDTH=1 needs no special-case slice.
    assign sum_nxt = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic; DONE lasts one cycle and may re-accept directly.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = DONE;
            DONE:    nstate = start ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Operand/result shifting, carry, counter and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sr <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_carry;
            sum_sr <= sum_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= sum_nxt;
                cout <= fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.
module tb_bit_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q1[$];

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // WIDTH=8 monitor.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8 sum", 32'(sum8), 32'(e.sum));
                chk("w8 cout", 32'(cout8), 32'(e.cout));
                chk("w8 done cycle", 32'(cyc), 32'(e.cyc));
                chk("w8 busy at done", 32'(busy8), 32'd0);
            end
        end
    end

    // WIDTH=1 monitor.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                chk("w1 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("w1 sum", 32'(sum1), 32'(e.sum[0]));
                chk("w1 cout", 32'(cout1), 32'(e.cout));
                chk("w1 done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one WIDTH=8 op; returns the cycle number of the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, output int c0);
        exp_t e;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start8 = 1'b0;
        e.sum = es; e.cout = ec; e.cyc = c0 + 8;
        q8.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk(name, 32'(q8.size() + q1.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int         c0;
        exp_t       e;
        logic [1:0] tt [8];
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset values.
        #12;
        chk("reset busy8", 32'(busy8), 0);
        chk("reset done8", 32'(done8), 0);
        chk("reset sum8", 32'(sum8), 0);
        chk("reset cout8", 32'(cout8), 0);
        chk("reset busy1", 32'(busy1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero operands; busy must stay high for exactly 8 cycles.
        issue8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, c0);
        for (int i = 0; i < 8; i++) begin
            chk("busy during run", 32'(busy8), 32'd1);
            if (i < 7) @(negedge clk);
        end
        drain("drain zero");

        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, c0);
        drain("drain ff+01");
        issue8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, c0);
        drain("drain a5+5a+1");
        issue8(8'h3C, 8'h21, 1'b0, 8'h5D, 1'b0, c0);
        drain("drain 3c+21");

        // Start during RUN is ignored.
        issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, c0);
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        drain("drain ignored start");

        // Back-to-back: start held through DONE.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        a8 = 8'h01; b8 = 8'h01;
        e.sum = 8'h46; e.cout = 1'b0; e.cyc = c0 + 8;
        q8.push_back(e);
        e.sum = 8'h02; e.cout = 1'b0; e.cyc = c0 + 17;
        q8.push_back(e);
        repeat (9) @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b busy after re-accept", 32'(busy8), 32'd1);
        drain("drain back-to-back");

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(busy8), 0);
        chk("mid reset done", 32'(done8), 0);
        chk("mid reset sum", 32'(sum8), 0);
        chk("mid reset cout", 32'(cout8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no done after reset sum", 32'(sum8), 0);
        issue8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, c0);
        drain("drain after reset");

        // WIDTH=1: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            e.sum = {7'd0, tt[i][0]}; e.cout = tt[i][1]; e.cyc = cyc + 1;
            q1.push_back(e);
            drain("drain w1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle W-bit adder built on the team's existing single-bit full adder, `f_adder` (ports a, b, c, sum, carry).
- Each clock it feeds one LSB-first bit pair plus a registered carry into `f_adder`, then shifts the sum bit into a result shift register.
- Trades latency for area; used where a wide parallel adder is unjustified.
- Start/busy/done handshake toward the controlling stage.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  request; sampled only when the block is idle or done
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result; holds the last completed value
- cout  output  1  final carry; holds the last completed value

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry register and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge (acceptance edge E0):
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0
  - state<=RUN; busy=1 from E0.
- RUN, each edge:
  - `f_adder` inputs are a_sr[0], b_sr[0] and carry.
  - carry<=fa.carry; sum_sr<={fa.sum, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one with zero fill; cnt<=cnt+1.
- Completion edge: the edge with cnt==WIDTH-1 processes the MSB (edge E_WIDTH). On that edge:
  - sum<=final shift value (sum_sr shifted once more with the MSB sum bit)
  - cout<=fa.carry
  - state<=DONE; busy<=0; done<=1.
- DONE: lasts exactly one cycle.
  - start=0: state<=IDLE, done<=0.
  - start=1: accepted exactly as in IDLE (back-to-back), done<=0, busy<=1.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH edges after acceptance. Throughput is one result per WIDTH+1 cycles.
- start while RUN: ignored. Operands in flight are unaffected and no request is queued.
- a, b, cin may change freely after E0 without affecting the result.
- sum/cout:
  - change only on a completion edge or reset;
  - hold between operations, including through a new RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: clog2(WIDTH), minimum 1. With WIDTH=1, the first RUN edge is the completion edge.
- Reset mid-RUN:
  - all state clears immediately and no done is emitted;
  - sum/cout go to 0;
  - after rst_n rises, the next start behaves as from power-up.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module: one instance of the existing `f_adder`. All other logic (FSM, shift registers, counter, result registers) stays inline.

Test Plan:
- Reset then WIDTH=8; a=8'h00, b=8'h00, cin=0, start one cycle -> busy high for 8 cycles; done pulses once, exactly 8 edges after acceptance; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h21, cin=0 -> sum=8'h5D, cout=0.
- Run a=8'h0F, b=8'h01, cin=0. Three edges after acceptance, pulse start with a=8'hFF, b=8'hFF -> ignored; result sum=8'h10, cout=0; exactly one done pulse.
- Run a=8'h12, b=8'h34 with start held high through DONE, then apply a=8'h01, b=8'h01 -> first done gives sum=8'h46; the next op is accepted in the DONE cycle; second done comes 9 cycles after the first, with sum=8'h02.
- Start a=8'hFF, b=8'hFF, cin=1; assert rst_n=0 asynchronously mid-cycle after 3 RUN edges -> busy, done, sum and cout drop to 0 immediately; no done after release. A fresh op a=8'h01, b=8'h02 -> sum=8'h03.
- WIDTH=1 instance: apply all 8 (a,b,cin) combinations 0..7 sequentially -> each done arrives 1 edge after acceptance; {cout,sum} equals the full-adder truth table (00,01,01,10,01,10,10,11).
